// File: rtl/pn_pkg.sv
// Shared encodings for the Polish Notation token path: modes, operator codes,
// transmitter states, error codes and small index/config helpers.
package pn_pkg;

  localparam int MAX_TOK = 12;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    MODE_PRE_TRI  = 2'd0,
    MODE_POST_TRI = 2'd1,
    MODE_PRE_EXP  = 2'd2,
    MODE_POST_EXP = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_ABS = 3'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_SEND,
    ST_WAIT
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_CFG    = 2'd1,
    ERR_SYNTAX = 2'd2
  } err_e;

  // Triple modes need whole triples; every mode needs 1..MAX_TOK tokens.
  function automatic logic cfg_ok(input logic [1:0] mode, input logic [CNT_W-1:0] len);
    logic ok;
    ok = (len != '0) && (len <= CNT_W'(MAX_TOK));
    if (mode == MODE_PRE_TRI || mode == MODE_POST_TRI)
      ok = ok && ((len % 4'd3) == 4'd0);
    return ok;
  endfunction

  // Postfix triples rotate (op, a, b) into (a, b, op); all other modes are in order.
  function automatic logic [CNT_W-1:0] emit_idx(input logic [1:0] mode,
                                                input logic [CNT_W-1:0] base,
                                                input logic [1:0] pos);
    logic [1:0] off;
    off = pos;
    if (mode == MODE_POST_TRI)
      off = (pos == 2'd2) ? 2'd0 : pos + 2'd1;
    return base + {{(CNT_W-2){1'b0}}, off};
  endfunction

endpackage

// File: rtl/pn_stream_tx_if.sv
// Token bus between the stream transmitter and the PN evaluator.
interface pn_stream_tx_if;
  logic       pn_in_valid;
  logic [1:0] pn_mode;
  logic       pn_operator;
  logic [2:0] pn_in;
  logic       pn_out_valid;

  modport master (output pn_in_valid, pn_mode, pn_operator, pn_in, input pn_out_valid);
  modport slave  (input pn_in_valid, pn_mode, pn_operator, pn_in, output pn_out_valid);
endinterface

// File: rtl/pn_syntax_chk.sv
// Per-token syntax checker: op-code range, triple shape, prefix need / postfix depth.
// o_err is sticky until i_clear; o_final_ok judges the count after the last token.
module pn_syntax_chk
  import pn_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic [1:0] i_mode,
  input  logic       i_tok_valid,
  input  logic       i_operator,
  input  logic [2:0] i_data,
  output logic       o_err,
  output logic       o_final_ok
);

  localparam logic [CNT_W:0] CNT_ONE = 1;
  localparam logic [CNT_W:0] CNT_TWO = 2;

  logic [CNT_W:0] r_cnt;
  logic [1:0]     r_tri_pos;
  logic           r_err;
  logic           w_tok_err;
  logic [CNT_W:0] w_cnt_next;

  always_comb begin
    w_tok_err  = i_operator && (i_data > OP_ABS);
    w_cnt_next = r_cnt;
    case (i_mode)
      MODE_PRE_EXP: begin
        if (r_cnt == '0)     w_tok_err  = 1'b1;
        else if (i_operator) w_cnt_next = r_cnt + CNT_ONE;
        else                 w_cnt_next = r_cnt - CNT_ONE;
      end
      MODE_POST_EXP: begin
        if (!i_operator)           w_cnt_next = r_cnt + CNT_ONE;
        else if (r_cnt < CNT_TWO)  w_tok_err  = 1'b1;
        else                       w_cnt_next = r_cnt - CNT_ONE;
      end
      default: begin
        if (i_operator != (r_tri_pos == 2'd0)) w_tok_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_tri_pos <= '0;
      r_err     <= 1'b0;
    end else if (i_clear) begin
      r_cnt     <= (i_mode == MODE_PRE_EXP) ? CNT_ONE : '0;
      r_tri_pos <= '0;
      r_err     <= 1'b0;
    end else if (i_tok_valid) begin
      if (w_tok_err) r_err <= 1'b1;
      r_cnt     <= w_cnt_next;
      r_tri_pos <= (r_tri_pos == 2'd2) ? 2'd0 : r_tri_pos + 2'd1;
    end
  end

  always_comb begin
    case (i_mode)
      MODE_PRE_EXP:  o_final_ok = (r_cnt == '0);
      MODE_POST_EXP: o_final_ok = (r_cnt == CNT_ONE);
      default:       o_final_ok = (r_tri_pos == 2'd0);
    endcase
  end

  assign o_err = r_err;

endmodule

// File: rtl/pn_stream_tx.sv
// Frame buffer + transmitter feeding the PN evaluator: load, syntax-check,
// send (with triple reordering), then wait for the evaluator's result burst.
module pn_stream_tx
  import pn_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_valid,
  input  logic [1:0]       i_cfg_mode,
  input  logic [CNT_W-1:0] i_cfg_len,
  input  logic             i_ld_valid,
  output logic             o_ld_ready,
  input  logic             i_ld_operator,
  input  logic [2:0]       i_ld_data,
  pn_stream_tx_if.master   pn,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic             o_frame_err,
  output logic [1:0]       o_err_code
);

  state_e           r_state;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] r_base;
  logic [1:0]       r_pos;
  logic             r_seen_ov;
  logic             r_frame_done;
  logic             r_frame_err;
  logic [1:0]       r_err_code;
  logic             r_pn_valid;
  logic [1:0]       r_pn_mode;
  logic             r_pn_op;
  logic [2:0]       r_pn_data;

  logic             r_buf_op   [MAX_TOK];
  logic [2:0]       r_buf_data [MAX_TOK];

  logic             w_cfg_take;
  logic             w_accept;
  logic             w_emit;
  logic             w_chk_err;
  logic             w_chk_ok;
  logic             w_chk_bad;
  logic [1:0]       w_chk_mode;
  logic [CNT_W-1:0] w_idx;

  assign w_cfg_take = (r_state == ST_IDLE) && i_cfg_valid;
  assign w_accept   = (r_state == ST_LOAD) && i_ld_valid;
  assign w_chk_mode = w_cfg_take ? i_cfg_mode : r_mode;
  assign w_chk_bad  = w_chk_err || !w_chk_ok;
  assign w_idx      = emit_idx(r_mode, r_base, r_pos);
  assign w_emit     = ((r_state == ST_CHECK) && !w_chk_bad) ||
                      ((r_state == ST_SEND) && (r_sent != r_len));

  pn_syntax_chk u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_cfg_take),
    .i_mode      (w_chk_mode),
    .i_tok_valid (w_accept),
    .i_operator  (i_ld_operator),
    .i_data      (i_ld_data),
    .o_err       (w_chk_err),
    .o_final_ok  (w_chk_ok)
  );

  // Buffer contents need no reset: a frame is only read after being fully loaded.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf_op[r_wr_ptr]   <= i_ld_operator;
      r_buf_data[r_wr_ptr] <= i_ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_mode       <= '0;
      r_len        <= '0;
      r_wr_ptr     <= '0;
      r_seen_ov    <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_cfg_valid) begin
            r_mode   <= i_cfg_mode;
            r_len    <= i_cfg_len;
            r_wr_ptr <= '0;
            if (cfg_ok(i_cfg_mode, i_cfg_len)) begin
              r_err_code <= ERR_NONE;
              r_state    <= ST_LOAD;
            end else begin
              r_err_code  <= ERR_CFG;
              r_frame_err <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (i_ld_valid) begin
            r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            if (r_wr_ptr + CNT_W'(1) == r_len) r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_chk_bad) begin
            r_err_code  <= ERR_SYNTAX;
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (r_sent == r_len) begin
            r_seen_ov <= 1'b0;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Completion is the falling edge of the evaluator's out_valid burst.
          if (pn.pn_out_valid) begin
            r_seen_ov <= 1'b1;
          end else if (r_seen_ov) begin
            r_frame_done <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pn_valid <= 1'b0;
      r_pn_mode  <= '0;
      r_pn_op    <= 1'b0;
      r_pn_data  <= '0;
      r_sent     <= '0;
      r_base     <= '0;
      r_pos      <= '0;
    end else begin
      if (w_emit) begin
        r_pn_valid <= 1'b1;
        r_pn_mode  <= r_mode;
        r_pn_op    <= r_buf_op[w_idx];
        r_pn_data  <= r_buf_data[w_idx];
      end else begin
        r_pn_valid <= 1'b0;
        r_pn_mode  <= '0;
        r_pn_op    <= 1'b0;
        r_pn_data  <= '0;
      end
      if (w_cfg_take) begin
        r_sent <= '0;
        r_base <= '0;
        r_pos  <= '0;
      end else if (w_emit) begin
        r_sent <= r_sent + CNT_W'(1);
        if (r_pos == 2'd2) begin
          r_pos  <= 2'd0;
          r_base <= r_base + CNT_W'(3);
        end else begin
          r_pos  <= r_pos + 2'd1;
        end
      end
    end
  end

  assign pn.pn_in_valid = r_pn_valid;
  assign pn.pn_mode     = r_pn_mode;
  assign pn.pn_operator = r_pn_op;
  assign pn.pn_in       = r_pn_data;

  assign o_ld_ready   = (r_state == ST_LOAD);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_err_code   = r_err_code;

endmodule

// File: tb/tb_pn_stream_tx.sv
// Directed bench for pn_stream_tx: frame-level model predicts the token stream,
// a per-cycle compare process checks the evaluator bus, tasks check timing/errors.
module tb_pn_stream_tx;
  import pn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_len = '0;
  logic       ld_valid = 1'b0;
  logic       ld_operator = 1'b0;
  logic [2:0] ld_data = '0;
  logic       ld_ready, busy, frame_done, frame_err;
  logic [1:0] err_code;

  pn_stream_tx_if pn();

  pn_stream_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cfg_valid   (cfg_valid),
    .i_cfg_mode    (cfg_mode),
    .i_cfg_len     (cfg_len),
    .i_ld_valid    (ld_valid),
    .o_ld_ready    (ld_ready),
    .i_ld_operator (ld_operator),
    .i_ld_data     (ld_data),
    .pn            (pn),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .o_frame_err   (frame_err),
    .o_err_code    (err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  // Token encoding used throughout: bit 3 = operator flag, bits 2:0 = code/value.
  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] tok;
  } exp_t;

  exp_t        exp_q[$];
  logic [47:0] got_vec;
  int          tok_cnt, first_cyc, last_cyc;
  logic [3:0]  tv [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (pn.pn_in_valid) begin
        if (tok_cnt == 0) first_cyc = cyc;
        last_cyc = cyc;
        tok_cnt++;
        got_vec = {got_vec[43:0], pn.pn_operator, pn.pn_in};
        if (exp_q.size() == 0) begin
          chk("unexpected_token", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("token", {pn.pn_mode, pn.pn_operator, pn.pn_in}, e);
        end
      end else begin
        chk("idle_bus_zero", {pn.pn_mode, pn.pn_operator, pn.pn_in}, 64'd0);
      end
    end
  end

  // Whole-frame verdict: 0 ok, 1 config error, 2 syntax error.
  function automatic int model_code(input logic [1:0] m, input int len);
    int cnt;
    if (len == 0 || len > 12 || (m < 2 && len % 3 != 0)) return 1;
    cnt = (m == 2) ? 1 : 0;
    for (int i = 0; i < len; i++) begin
      logic is_op;
      is_op = tv[i][3];
      if (is_op && tv[i][2:0] > 3) return 2;
      case (m)
        2'd2: begin
          if (cnt == 0) return 2;
          cnt += is_op ? 1 : -1;
        end
        2'd3: begin
          if (is_op) begin
            if (cnt < 2) return 2;
            cnt--;
          end else begin
            cnt++;
          end
        end
        default: if (is_op != (i % 3 == 0)) return 2;
      endcase
    end
    if (m == 2 && cnt != 0) return 2;
    if (m == 3 && cnt != 1) return 2;
    return 0;
  endfunction

  task automatic prep(input logic [1:0] m, input int len, input logic [47:0] toks);
    int idx;
    for (int i = 0; i < 12; i++)
      tv[i] = (i < len && len <= 12) ? toks[(len-1-i)*4 +: 4] : 4'h0;
    exp_q.delete();
    if (model_code(m, len) == 0) begin
      for (int i = 0; i < len; i++) begin
        idx = (m == 2'd1) ? (i / 3) * 3 + ((i % 3) + 1) % 3 : i;
        exp_q.push_back({m, tv[idx]});
      end
    end
    tok_cnt = 0;
    got_vec = '0;
  endtask

  task automatic load_tokens(input int len);
    for (int i = 0; i < len; i++) begin
      ld_valid    = 1'b1;
      ld_operator = tv[i][3];
      ld_data     = tv[i][2:0];
      step();
    end
    ld_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] m, input int len, input logic [47:0] toks,
                           input int exp_code, input logic [47:0] exp_stream);
    int last_acc;
    int guard;
    prep(m, len, toks);
    $display("frame mode=%0d len=%0d expected_code=%0d", m, len, exp_code);
    cfg_valid = 1'b1;
    cfg_mode  = m;
    cfg_len   = len[3:0];
    step();
    cfg_valid = 1'b0;
    if (exp_code == 1) begin
      chk("cfg_err_pulse", frame_err, 1);
      chk("cfg_err_code", err_code, 1);
      chk("cfg_err_ld_ready", ld_ready, 0);
      step();
      chk("cfg_err_pulse_end", frame_err, 0);
      chk("cfg_err_ld_ready_hold", ld_ready, 0);
      chk("cfg_err_busy", busy, 0);
      return;
    end
    chk("load_ld_ready", ld_ready, 1);
    chk("load_busy", busy, 1);
    chk("err_code_cleared", err_code, 0);
    load_tokens(len);
    last_acc = cyc - 1;
    chk("ld_ready_after_last", ld_ready, 0);
    if (exp_code == 2) begin
      step();
      chk("syn_err_pulse", frame_err, 1);
      chk("syn_err_code", err_code, 2);
      chk("syn_err_busy", busy, 0);
      step();
      chk("syn_err_pulse_end", frame_err, 0);
      chk("syn_err_code_hold", err_code, 2);
      chk("syn_err_no_tokens", tok_cnt, 0);
      return;
    end
    guard = 0;
    while ((exp_q.size() != 0 || pn.pn_in_valid) && guard < 40) begin
      step();
      guard++;
    end
    chk("stream_in_time", guard < 40, 1);
    chk("first_token_latency", first_cyc - last_acc, 2);
    chk("burst_contiguous", last_cyc - first_cyc + 1, len);
    chk("token_count", tok_cnt, len);
    chk("stream_literal", got_vec, exp_stream);
    chk("wait_busy", busy, 1);
    chk("no_early_done", frame_done, 0);
    pn.pn_out_valid = 1'b1;
    repeat (2) step();
    chk("done_held_while_ov", frame_done, 0);
    pn.pn_out_valid = 1'b0;
    step();
    chk("frame_done_pulse", frame_done, 1);
    chk("done_err_code", err_code, 0);
    step();
    chk("frame_done_end", frame_done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    pn.pn_out_valid = 1'b0;
    step();
    step();
    chk("in_reset_valid", pn.pn_in_valid, 0);
    rst_n = 1'b1;
    step();
    chk("reset_valid", pn.pn_in_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ld_ready", ld_ready, 0);
    chk("reset_err_code", err_code, 0);
    chk("reset_done_err", {frame_done, frame_err}, 0);

    run_frame(2'd0, 6,  48'hA45812, 0, 48'hA45812);
    run_frame(2'd1, 6,  48'hA45812, 0, 48'h45A128);
    run_frame(2'd3, 5,  48'h3482A,  0, 48'h3482A);
    run_frame(2'd2, 5,  48'h98123,  0, 48'h98123);
    run_frame(2'd3, 3,  48'h384,    2, 48'h0);
    run_frame(2'd0, 4,  48'h0,      1, 48'h0);
    run_frame(2'd2, 13, 48'h0,      1, 48'h0);
    run_frame(2'd2, 3,  48'hD12,    2, 48'h0);
    run_frame(2'd2, 2,  48'h12,     2, 48'h0);
    run_frame(2'd0, 12, 48'h812934A56B70, 0, 48'h812934A56B70);

    // Asynchronous reset in the middle of a transmitted frame.
    prep(2'd0, 6, 48'hA45812);
    $display("frame mode=0 len=6 reset at third token");
    cfg_valid = 1'b1;
    cfg_mode  = 2'd0;
    cfg_len   = 4'd6;
    step();
    cfg_valid = 1'b0;
    load_tokens(6);
    guard = 0;
    while (tok_cnt < 3 && guard < 20) begin
      step();
      guard++;
    end
    chk("reached_third_token", tok_cnt, 3);
    chk("third_token_valid", pn.pn_in_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", pn.pn_in_valid, 0);
    chk("async_rst_busy", busy, 0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    run_frame(2'd0, 3, 48'hB71, 0, 48'hB71);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
